program_loader: RTL and testbench

Loads a program image into the 16-bit-word instruction memory, writing it through a dedicated write port while the CPU is held. The image arrives as a byte stream with valid/ready handshake (from the host/UART side). It has a 2-byte word-count header, the payload words, and a 1-byte XOR checksum. The loader writes each assembled 16-bit word to consecutive addresses from `BASE_ADDR`, then reports `done` or `error`.

---
 rtl/program_loader_if.sv | 30 +++
 rtl/program_loader.sv | 155 +++++++++++++++
 tb/tb_program_loader.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_loader_if : byte-stream input and instruction-memory write bus
// Revision 1.0
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic        error;

  // master = host / stream source side, slave = loader side
  modport master (
    output start, in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata, busy, cpu_hold, done, error
  );
endinterface
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// program_loader : parses a length/payload/XOR-checksum byte stream and writes
// big-endian 16-bit words into instruction memory from BASE_ADDR.
// Revision 1.0
// ---------------------------------------------------------------------------
module program_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000
) (
  input  wire logic       clk,
  input  wire logic       rst,
  program_loader_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] count, count_nxt;
  logic [15:0] index, index_nxt;
  logic [7:0]  hold, hold_nxt;
  logic [7:0]  acc, acc_nxt;
  logic        we, we_nxt;
  logic [15:0] addr, addr_nxt;
  logic [15:0] wdata, wdata_nxt;
  logic        done_r, done_nxt;
  logic        error_r, error_nxt;

  logic        loading;
  logic        accept;
  logic [15:0] index_inc;
  logic [15:0] len_word;

  assign loading   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                     (state == S_DATA_HI) || (state == S_DATA_LO) ||
                     (state == S_CSUM);
  assign accept    = bus.in_valid && loading;
  assign index_inc = index + 16'd1;
  assign len_word  = {count[15:8], bus.in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= 16'h0000;
      index   <= 16'h0000;
      hold    <= 8'h00;
      acc     <= 8'h00;
      we      <= 1'b0;
      addr    <= 16'h0000;
      wdata   <= 16'h0000;
      done_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      index   <= index_nxt;
      hold    <= hold_nxt;
      acc     <= acc_nxt;
      we      <= we_nxt;
      addr    <= addr_nxt;
      wdata   <= wdata_nxt;
      done_r  <= done_nxt;
      error_r <= error_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    index_nxt = index;
    hold_nxt  = hold;
    acc_nxt   = acc;
    we_nxt    = 1'b0;
    addr_nxt  = addr;
    wdata_nxt = wdata;
    done_nxt  = done_r;
    error_nxt = error_r;

    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          done_nxt  = 1'b0;
          error_nxt = 1'b0;
          acc_nxt   = 8'h00;
          index_nxt = 16'h0000;
          count_nxt = 16'h0000;
          state_nxt = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (accept) begin
          count_nxt = {bus.in_data, count[7:0]};
          acc_nxt   = acc ^ bus.in_data;
          state_nxt = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (accept) begin
          count_nxt = len_word;
          acc_nxt   = acc ^ bus.in_data;
          state_nxt = (len_word != 16'h0000) ? S_DATA_HI : S_CSUM;
        end
      end
      S_DATA_HI: begin
        if (accept) begin
          hold_nxt  = bus.in_data;
          acc_nxt   = acc ^ bus.in_data;
          state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (accept) begin
          // Address arithmetic is 16-bit so the image may wrap past 16'hFFFF.
          we_nxt    = 1'b1;
          wdata_nxt = {hold, bus.in_data};
          addr_nxt  = BASE_ADDR + index;
          index_nxt = index_inc;
          acc_nxt   = acc ^ bus.in_data;
          state_nxt = (index_inc == count) ? S_CSUM : S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (accept) begin
          if (bus.in_data == acc) begin
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            error_nxt = 1'b1;
            state_nxt = S_ERR;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.in_ready  = loading;
  assign bus.busy      = loading;
  assign bus.cpu_hold  = loading;
  assign bus.mem_we    = we;
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
  assign bus.done      = done_r;
  assign bus.error     = error_r;

endmodule
`default_nettype wire

// File: tb/tb_program_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_program_loader : directed and randomized image loads against a
// stream-level model of expected writes and final status.
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  bit         sel = 1'b0;
  bit         pend_lo = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0]  stim[$];
  logic [31:0] exp_q[$];
  logic [31:0] got[$];
  bit          exp_good;

  always #5 clk = ~clk;

  program_loader_if b0 ();
  program_loader_if b1 ();

  assign b0.start = start;  assign b0.in_data = in_data;  assign b0.in_valid = in_valid;
  assign b1.start = start;  assign b1.in_data = in_data;  assign b1.in_valid = in_valid;

  program_loader #(.BASE_ADDR(16'h0000)) dut0 (.clk(clk), .rst(rst), .bus(b0));
  program_loader #(.BASE_ADDR(16'hFFFF)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  logic        m_in_ready, m_we, m_busy, m_hold, m_done, m_error;
  logic [15:0] m_addr, m_wdata;
  assign m_in_ready = sel ? b1.in_ready  : b0.in_ready;
  assign m_we       = sel ? b1.mem_we    : b0.mem_we;
  assign m_addr     = sel ? b1.mem_addr  : b0.mem_addr;
  assign m_wdata    = sel ? b1.mem_wdata : b0.mem_wdata;
  assign m_busy     = sel ? b1.busy      : b0.busy;
  assign m_hold     = sel ? b1.cpu_hold  : b0.cpu_hold;
  assign m_done     = sel ? b1.done      : b0.done;
  assign m_error    = sel ? b1.error     : b0.error;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Expected writes and verdict computed straight from the image layout.
  task automatic build_model(input logic [15:0] base);
    int unsigned n;
    logic [7:0]  x;
    exp_q.delete();
    n = {stim[0], stim[1]};
    x = 8'h00;
    for (int i = 0; i < 2 + 2 * int'(n); i++) x ^= stim[i];
    for (int i = 0; i < int'(n); i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      exp_q.push_back({a, stim[2 + 2 * i], stim[3 + 2 * i]});
    end
    exp_good = (stim[2 + 2 * n] == x);
  endtask

  function automatic bit is_lo(input int k, input int n);
    return (k >= 2) && (k < 2 + 2 * n) && (((k - 2) % 2) == 1);
  endfunction

  // Per-cycle compare: write pulses must match the model queue in order and
  // appear exactly one cycle after each low payload byte is accepted.
  bit pend;
  initial begin
    forever begin
      @(negedge clk); #1;
      pend = pend_lo && in_valid && m_in_ready && !rst;
      @(posedge clk); #2;
      if (!rst) begin
        chk(m_we === pend, "we_timing", {31'd0, m_we}, {31'd0, pend});
        chk(m_hold === m_busy && m_in_ready === m_busy, "hold_ready_eq_busy",
            {m_hold, m_in_ready}, {m_busy, m_busy});
        if (m_we === 1'b1) begin
          got.push_back({m_addr, m_wdata});
          if (exp_q.size() == 0)
            chk(1'b0, "unexpected_write", {m_addr, m_wdata}, 32'h0);
          else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            chk({m_addr, m_wdata} === e, "write_addr_data", {m_addr, m_wdata}, e);
          end
        end
      end
    end
  end

  task automatic check_reset_vals(input string name);
    chk({m_in_ready, m_we, m_addr, m_wdata, m_busy, m_hold, m_done, m_error} === 39'd0, name,
        {m_in_ready, m_we, m_busy, m_hold, m_done, m_error, 10'd0, m_addr}, 32'h0);
  endtask

  task automatic do_load(input int gap_pct, input bit mid_start, input int abort_at);
    int n;
    n = {stim[0], stim[1]};
    build_model(sel ? 16'hFFFF : 16'h0000);
    got.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk(m_busy === 1'b1 && m_in_ready === 1'b1, "busy_after_start", {m_busy, m_in_ready}, 2'b11);
    for (int k = 0; k < stim.size(); k++) begin
      if (k == abort_at) break;
      for (int g = 0; g < 3; g++) begin
        if ($urandom_range(99) >= gap_pct) break;
        in_valid = 1'b0; pend_lo = 1'b0;
        start = mid_start && ($urandom_range(1) == 1);
        @(negedge clk); start = 1'b0;
      end
      in_data = stim[k]; in_valid = 1'b1; pend_lo = is_lo(k, n);
      start = mid_start && (k == 3);
      chk(m_in_ready === 1'b1, "in_ready_mid_load", {31'd0, m_in_ready}, 32'd1);
      @(negedge clk); start = 1'b0;
    end
    in_valid = 1'b0; pend_lo = 1'b0;
    if (abort_at >= 0) begin
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("reset_mid_load_outputs");
      exp_q.delete();
      @(negedge clk); rst = 1'b0;
    end else begin
      chk(m_done === exp_good && m_error === !exp_good && m_busy === 1'b0, "final_status",
          {m_done, m_error, m_busy}, {exp_good, !exp_good, 1'b0});
      @(negedge clk);
      chk(exp_q.size() == 0, "all_writes_seen", exp_q.size(), 32'd0);
    end
  endtask

  task automatic set_stim(input logic [7:0] b[]);
    stim.delete();
    foreach (b[i]) stim.push_back(b[i]);
  endtask

  task automatic gen_random(input int n, input bit corrupt);
    logic [7:0] x, v;
    stim.delete();
    stim.push_back(8'(n >> 8));
    stim.push_back(8'(n));
    for (int i = 0; i < 2 * n; i++) begin
      v = 8'($urandom);
      stim.push_back(v);
    end
    x = 8'h00;
    foreach (stim[i]) x ^= stim[i];
    stim.push_back(corrupt ? (x ^ 8'($urandom_range(255, 1))) : x);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst = 1'b0;

    // Basic load; pin the model and the DUT to hand-computed values.
    set_stim('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    build_model(16'h0000);
    chk(exp_q.size() == 2 && exp_q[0] == 32'h0000_1234 && exp_q[1] == 32'h0001_ABCD && exp_good,
        "model_basic", exp_q.size(), 32'd2);
    do_load(0, 1'b0, -1);
    chk(got.size() == 2 && got[0] == 32'h0000_1234 && got[1] == 32'h0001_ABCD, "basic_writes",
        got.size() > 1 ? got[1] : 32'h0, 32'h0001_ABCD);
    chk(m_done === 1'b1 && m_error === 1'b0, "basic_done", {m_done, m_error}, 2'b10);

    // Bad checksum.
    set_stim('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43});
    do_load(0, 1'b0, -1);
    chk(got.size() == 2 && m_error === 1'b1 && m_done === 1'b0, "bad_csum",
        {m_done, m_error}, 2'b01);

    // Empty image.
    set_stim('{8'h00, 8'h00, 8'h00});
    do_load(0, 1'b0, -1);
    chk(got.size() == 0 && m_done === 1'b1, "empty_image", got.size(), 32'd0);

    // Address wrap on the FFFF-based instance.
    sel = 1'b1;
    set_stim('{8'h00, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'h01});
    do_load(0, 1'b0, -1);
    chk(got.size() == 2 && got[0] == 32'hFFFF_0001 && got[1] == 32'h0000_0002 && m_done === 1'b1,
        "addr_wrap", got.size() > 1 ? got[1] : 32'h0, 32'h0000_0002);
    sel = 1'b0;

    // Gapped stream with ignored start pulses.
    set_stim('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42});
    do_load(50, 1'b1, -1);
    chk(got.size() == 2 && got[0] == 32'h0000_1234 && got[1] == 32'h0001_ABCD && m_done === 1'b1,
        "gapped_start_ignored", got.size(), 32'd2);

    // Reset mid-load, then a clean reload.
    do_load(0, 1'b0, 5);
    chk(got.size() == 1, "reset_no_second_write", got.size(), 32'd1);
    do_load(0, 1'b0, -1);
    chk(m_done === 1'b1 && got.size() == 2, "reload_after_reset", {31'd0, m_done}, 32'd1);

    // Count with a nonzero high byte.
    gen_random(16'h0103, 1'b0);
    do_load(10, 1'b0, -1);
    chk(got.size() == 259, "long_image_count", got.size(), 32'd259);

    // Randomized loads on both instances.
    for (int t = 0; t < 24; t++) begin
      sel = ($urandom_range(1) == 1);
      gen_random($urandom_range(6), $urandom_range(2) == 0);
      do_load($urandom_range(40), $urandom_range(1) == 1, -1);
    end

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
